// File: rtl/nvio_pit_sched.sv
// Shares the three nvio PIT channels among NREQ one-shot delay requesters:
// round-robin grant, Wishbone programming of a free channel, done on terminal count.
module nvio_pit_sched #(
   parameter int NREQ  = 4,
   parameter int RBITS = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   delay,
   output logic [NREQ-1:0]      req_ack,
   output logic [NREQ-1:0]      done,
   output logic [2:0]           busy,
   output logic                 cyc_o,
   output logic                 stb_o,
   output logic                 we_o,
   output logic [3:0]           sel_o,
   output logic [5:0]           adr_o,
   output logic [31:0]          dat_o,
   input  logic                 ack_i,
   input  logic [2:0]           pit_out
);

   typedef enum logic [1:0] {IDLE, WR_MAX, WR_ONT, WR_CTL} state_t;

   state_t            state;
   logic [RBITS-1:0]  ptr;
   logic [RBITS-1:0]  owner [3];
   logic [2:0]        pit_q;
   logic [1:0]        chan;

   logic              r_found, n_found, gnt_ok;
   logic [RBITS-1:0]  cand, gnt_r;
   logic [1:0]        gnt_n;
   logic [31:0]       gnt_d;
   logic [2:0]        fall, busy_nxt;
   logic [NREQ-1:0]   done_nxt;

   // Arbitration sees busy before this edge's expiries, so a freed channel
   // only becomes grantable one cycle later.
   always_comb begin
      r_found = 1'b0;
      n_found = 1'b0;
      cand    = '0;
      gnt_r   = '0;
      gnt_n   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = RBITS'((32'(ptr) + k) % NREQ);
         if (!r_found && req[cand]) begin
            r_found = 1'b1;
            gnt_r   = cand;
         end
      end
      for (int unsigned k = 0; k < 3; k++) begin
         if (!n_found && !busy[k]) begin
            n_found = 1'b1;
            gnt_n   = 2'(k);
         end
      end
      gnt_ok = (state == IDLE) && r_found && n_found;
      gnt_d  = delay[{gnt_r, 5'd0} +: 32];
      if (gnt_d == 32'd0)
         gnt_d = 32'd1;

      fall     = pit_q & ~pit_out & busy;
      done_nxt = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         if (fall[k])
            done_nxt[owner[k]] = 1'b1;
      end
      busy_nxt = busy & ~fall;
      if (gnt_ok)
         busy_nxt[gnt_n] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= '0;
         pit_q   <= '0;
         chan    <= '0;
         req_ack <= '0;
         done    <= '0;
         busy    <= '0;
         cyc_o   <= 1'b0;
         stb_o   <= 1'b0;
         we_o    <= 1'b0;
         sel_o   <= '0;
         adr_o   <= '0;
         dat_o   <= '0;
         for (int unsigned k = 0; k < 3; k++)
            owner[k] <= '0;
      end else begin
         pit_q   <= pit_out;
         req_ack <= '0;
         done    <= done_nxt;
         busy    <= busy_nxt;
         case (state)
            IDLE: begin
               if (gnt_ok) begin
                  owner[gnt_n]   <= gnt_r;
                  chan           <= gnt_n;
                  req_ack[gnt_r] <= 1'b1;
                  ptr            <= (gnt_r == RBITS'(NREQ - 1)) ? '0 : gnt_r + 1'b1;
                  cyc_o          <= 1'b1;
                  stb_o          <= 1'b1;
                  we_o           <= 1'b1;
                  sel_o          <= 4'hF;
                  adr_o          <= {gnt_n, 4'h4};
                  dat_o          <= gnt_d;
                  state          <= WR_MAX;
               end
            end
            WR_MAX: begin
               if (ack_i) begin
                  adr_o <= {chan, 4'h8};
                  dat_o <= 32'd1;
                  state <= WR_ONT;
               end
            end
            WR_ONT: begin
               if (ack_i) begin
                  adr_o <= 6'h0C;
                  sel_o <= 4'b0001 << chan;
                  dat_o <= 32'h3 << {chan, 3'd0};
                  state <= WR_CTL;
               end
            end
            WR_CTL: begin
               if (ack_i) begin
                  cyc_o <= 1'b0;
                  stb_o <= 1'b0;
                  we_o  <= 1'b0;
                  sel_o <= '0;
                  adr_o <= '0;
                  dat_o <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nvio_pit_sched.sv
// Bench for nvio_pit_sched: behavioural PIT slave, directed scenarios and a
// randomized run against a cycle-level scheduling model.
module tb_nvio_pit_sched;

   localparam int NREQ  = 4;
   localparam int RBITS = 2;

   logic                clk = 1'b0;
   logic                rst_i;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  delay;
   logic [NREQ-1:0]     req_ack, done;
   logic [2:0]          busy;
   logic                cyc_o, stb_o, we_o, ack_i;
   logic [3:0]          sel_o;
   logic [5:0]          adr_o;
   logic [31:0]         dat_o;
   logic [2:0]          pit_out;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int stall_until = 0;
   int wbase = 0;
   logic pit_rst = 1'b0;

   typedef struct {
      int          e;
      logic [5:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
   } wr_t;
   wr_t wlog[$];

   logic [31:0] mc  [3] = '{default: 32'd0};
   logic [31:0] cnt [3] = '{default: 32'd0};

   nvio_pit_sched #(.NREQ(NREQ), .RBITS(RBITS)) dut (
      .clk_i(clk), .rst_i(rst_i), .req(req), .delay(delay),
      .req_ack(req_ack), .done(done), .busy(busy),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
      .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .pit_out(pit_out)
   );

   always #5 clk = ~clk;

   // PIT slave: same-cycle ack except while a WR_ONT stall window is open.
   assign ack_i = cyc_o && stb_o && !(adr_o[3:0] == 4'h8 && edge_n < stall_until);

   always_comb
      for (int n = 0; n < 3; n++)
         pit_out[n] = (cnt[n] == 32'd1);

   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      if (cyc_o && stb_o && ack_i && we_o)
         wlog.push_back('{edge_n + 1, adr_o, sel_o, dat_o});
      for (int n = 0; n < 3; n++) begin
         if (pit_rst) begin
            cnt[n] <= 32'd0;
            mc[n]  <= 32'd0;
         end else begin
            if (cyc_o && stb_o && ack_i && adr_o == 6'(16 * n + 4))
               mc[n] <= dat_o;
            if (cyc_o && stb_o && ack_i && adr_o == 6'h0C && sel_o[n] &&
                dat_o[8 * n] && dat_o[8 * n + 1])
               cnt[n] <= mc[n];
            else if (cnt[n] != 32'd0)
               cnt[n] <= cnt[n] - 32'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      pit_rst = 1'b1;
      req = '0;
      delay = '0;
      stall_until = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      pit_rst = 1'b0;
      wbase = wlog.size();
   endtask

   task automatic wait_done(input int maxc, output int at, output logic [NREQ-1:0] val);
      at = -1;
      val = '0;
      for (int i = 0; i < maxc && at < 0; i++) begin
         tick();
         if (done != '0) begin
            at = edge_n;
            val = done;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({cyc_o, stb_o, we_o} !== 3'b000) begin
         errors++; $display("FAIL reset_wb: got %b expected 000", {cyc_o, stb_o, we_o});
      end
      checks++;
      if ({req_ack, done, busy} !== '0) begin
         errors++; $display("FAIL reset_flags: got %h expected 0", {req_ack, done, busy});
      end
      checks++;
      if ({sel_o, adr_o, dat_o} !== '0) begin
         errors++; $display("FAIL reset_bus: got %h expected 0", {sel_o, adr_o, dat_o});
      end
   endtask

   task automatic test_single();
      int g, at;
      logic [NREQ-1:0] v;
      wr_t exp_w [3];
      do_reset();
      req = 4'b0001;
      delay[31:0] = 32'd10;
      tick();
      g = edge_n;
      checks++;
      if (req_ack !== 4'b0001 || busy !== 3'b001) begin
         errors++; $display("FAIL single_grant: ack=%b busy=%b expected 0001/001", req_ack, busy);
      end
      @(negedge clk);
      req = '0;
      exp_w[0] = '{g + 1, 6'h04, 4'hF, 32'd10};
      exp_w[1] = '{g + 2, 6'h08, 4'hF, 32'd1};
      exp_w[2] = '{g + 3, 6'h0C, 4'h1, 32'h3};
      wait_done(40, at, v);
      checks++;
      if (wlog.size() - wbase !== 3) begin
         errors++; $display("FAIL single_nwrites: got %0d expected 3", wlog.size() - wbase);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wlog[wbase + i] !== exp_w[i]) begin
               errors++;
               $display("FAIL single_write%0d: got e=%0d adr=%h sel=%h dat=%h expected e=%0d adr=%h sel=%h dat=%h",
                        i, wlog[wbase + i].e, wlog[wbase + i].adr, wlog[wbase + i].sel, wlog[wbase + i].dat,
                        exp_w[i].e, exp_w[i].adr, exp_w[i].sel, exp_w[i].dat);
            end
         end
      end
      checks++;
      if (at !== g + 3 + 11 || v !== 4'b0001) begin
         errors++; $display("FAIL single_done: at=%0d val=%b expected at=%0d val=0001", at, v, g + 14);
      end
      tick();
      checks++;
      if (done !== 4'b0000 || busy !== 3'b000) begin
         errors++; $display("FAIL single_after: done=%b busy=%b expected 0000/000", done, busy);
      end
   endtask

   task automatic test_four_and_fairness();
      int ack_at [NREQ];
      int done_at [NREQ];
      int a0;
      bit found;
      do_reset();
      for (int r = 0; r < NREQ; r++) begin
         ack_at[r] = -1;
         done_at[r] = -1;
         delay[32 * r +: 32] = 32'(50 + 10 * r);
      end
      req = 4'b1111;
      for (int i = 0; i < 300 && !(ack_at[3] >= 0 && done_at[1] >= 0); i++) begin
         tick();
         for (int r = 0; r < NREQ; r++) begin
            if (req_ack[r] && ack_at[r] < 0) ack_at[r] = edge_n;
            if (done[r] && done_at[r] < 0) done_at[r] = edge_n;
         end
         if (req_ack[2]) begin
            checks++;
            if (busy !== 3'b111) begin
               errors++; $display("FAIL four_busy_full: got %b expected 111", busy);
            end
         end
         @(negedge clk);
         req = req & ~req_ack;
      end
      a0 = ack_at[0];
      checks++;
      if (ack_at[1] !== a0 + 4 || ack_at[2] !== a0 + 8) begin
         errors++; $display("FAIL four_order: r1 at %0d r2 at %0d expected %0d %0d", ack_at[1], ack_at[2], a0 + 4, a0 + 8);
      end
      checks++;
      if (done_at[0] !== a0 + 54 || ack_at[3] !== a0 + 55) begin
         errors++; $display("FAIL four_r3_rebind: done0 at %0d ack3 at %0d expected %0d %0d",
                            done_at[0], ack_at[3], a0 + 54, a0 + 55);
      end
      found = 1'b0;
      for (int i = wbase; i < wlog.size(); i++) begin
         if (wlog[i].adr == 6'h0C && wlog[i].sel == 4'b0010 && !found) begin
            found = 1'b1;
            checks++;
            if (wlog[i].dat !== 32'h0300 || wlog[i].e !== a0 + 7) begin
               errors++; $display("FAIL four_ctl_ch1: dat=%h e=%0d expected 00000300 e=%0d", wlog[i].dat, wlog[i].e, a0 + 7);
            end
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL four_ctl_ch1_missing: got none expected one");
      end
      // r3 was granted last, so the pointer now favours r0 over r3.
      req = 4'b1001;
      delay[31:0] = 32'd5;
      delay[127:96] = 32'd5;
      tick();
      checks++;
      if (req_ack !== 4'b0001) begin
         errors++; $display("FAIL fairness: got %b expected 0001", req_ack);
      end
      @(negedge clk);
      req = '0;
   endtask

   task automatic test_zero_delay();
      int g, at;
      logic [NREQ-1:0] v;
      do_reset();
      req = 4'b0001;
      delay[31:0] = 32'd0;
      tick();
      g = edge_n;
      @(negedge clk);
      req = '0;
      wait_done(20, at, v);
      checks++;
      if (wlog.size() - wbase < 1 || wlog[wbase].dat !== 32'd1) begin
         errors++; $display("FAIL zero_maxcount: got %h expected 00000001",
                            (wlog.size() > wbase) ? wlog[wbase].dat : 32'hx);
      end
      checks++;
      if (at !== g + 3 + 2 || v !== 4'b0001) begin
         errors++; $display("FAIL zero_done: at=%0d val=%b expected at=%0d val=0001", at, v, g + 5);
      end
   endtask

   task automatic test_stall();
      int g, at;
      logic [NREQ-1:0] v;
      do_reset();
      req = 4'b0001;
      delay[31:0] = 32'd5;
      tick();
      g = edge_n;
      @(negedge clk);
      req = '0;
      tick();
      stall_until = edge_n + 3;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (!(cyc_o && stb_o && we_o) || adr_o !== 6'h08 || dat_o !== 32'd1) begin
            errors++; $display("FAIL stall_hold%0d: cyc=%b stb=%b adr=%h dat=%h expected 1 1 08 1", i, cyc_o, stb_o, adr_o, dat_o);
         end
      end
      wait_done(30, at, v);
      checks++;
      if (wlog.size() - wbase !== 3 || wlog[wbase + 1].e !== g + 5 || wlog[wbase + 2].e !== g + 6) begin
         errors++; $display("FAIL stall_writes: n=%0d expected 3 with ONT at %0d CTL at %0d", wlog.size() - wbase, g + 5, g + 6);
      end
      checks++;
      if (at !== g + 12 || v !== 4'b0001) begin
         errors++; $display("FAIL stall_done: at=%0d val=%b expected at=%0d val=0001", at, v, g + 12);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset();
      req = 4'b0001;
      delay[31:0] = 32'd30;
      tick();
      @(negedge clk);
      req = '0;
      for (int i = 0; i < 4; i++) tick();
      @(negedge clk);
      req = 4'b0010;
      delay[63:32] = 32'd7;
      tick();
      checks++;
      if (!cyc_o || adr_o !== 6'h14) begin
         errors++; $display("FAIL rstmid_inwrite: cyc=%b adr=%h expected 1 14", cyc_o, adr_o);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy !== 3'b000) begin
         errors++; $display("FAIL rstmid_drop: cyc=%b stb=%b busy=%b expected 0 0 000", cyc_o, stb_o, busy);
      end
      @(negedge clk);
      rst_i = 1'b0;
      req = '0;
      seen = 1'b0;
      for (int i = 0; i < 45; i++) begin
         tick();
         if (done != '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL rstmid_nodone: got a done pulse expected none");
      end
   endtask

   task automatic test_random();
      int unsigned ptr_m = 0, wr_left = 0, d;
      int own_m [3];
      int exp_at [3];
      logic [2:0] busy_m = '0, old;
      logic [NREQ-1:0] eack = '0, edone;
      int r, n;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         req = req & ~eack;
         for (int k = 0; k < NREQ; k++) begin
            if (!req[k] && $urandom_range(0, 7) == 0) begin
               req[k] = 1'b1;
               delay[32 * k +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
            end else if (req[k] && $urandom_range(0, 49) == 0) begin
               req[k] = 1'b0;
            end
         end
         old = busy_m;
         eack = '0;
         edone = '0;
         if (wr_left > 0) begin
            wr_left--;
         end else if (req != '0 && old != 3'b111) begin
            r = -1;
            for (int k = 0; k < NREQ; k++)
               if (r < 0 && req[(ptr_m + k) % NREQ]) r = int'((ptr_m + k) % NREQ);
            n = -1;
            for (int k = 0; k < 3; k++)
               if (n < 0 && !old[k]) n = k;
            d = delay[32 * r +: 32];
            if (d == 0) d = 1;
            busy_m[n] = 1'b1;
            own_m[n] = r;
            exp_at[n] = edge_n + 1 + int'(d) + 4;
            eack[r] = 1'b1;
            ptr_m = (r + 1) % NREQ;
            wr_left = 3;
         end
         for (int k = 0; k < 3; k++) begin
            if (old[k] && exp_at[k] == edge_n + 1) begin
               edone[own_m[k]] = 1'b1;
               busy_m[k] = 1'b0;
            end
         end
         tick();
         checks++;
         if (req_ack !== eack) begin
            errors++; $display("FAIL rand_ack @%0d: got %b expected %b", edge_n, req_ack, eack);
         end
         checks++;
         if (done !== edone) begin
            errors++; $display("FAIL rand_done @%0d: got %b expected %b", edge_n, done, edone);
         end
         checks++;
         if (busy !== busy_m) begin
            errors++; $display("FAIL rand_busy @%0d: got %b expected %b", edge_n, busy, busy_m);
         end
      end
      @(negedge clk);
      req = '0;
   endtask

   initial begin
      rst_i = 1'b1;
      req = '0;
      delay = '0;
      test_reset();
      test_single();
      test_four_and_fairness();
      test_zero_delay();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nvio_pit_sched.md
Name: nvio_pit_sched

Overview:
Scheduler that shares the three nvio PIT channels among NREQ one-shot delay requesters. It arbitrates requests round-robin and binds each granted request to a free PIT channel. It programs that channel as a Wishbone write master, then watches the channel's out pin and pulses done to the owning requester at terminal count. It sits between the PIT slave port and CPU-side or DMA-side requesters; the PIT remains the only counter datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
RBITS, 2, requester index width, $clog2(NREQ)

Ports:
clk_i  in  1  system clock, same clock as PIT clk_i
rst_i  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester delay request, level, held until req_ack
delay  in  32*NREQ  per-requester delay in clk_i cycles; slice r = delay[32r+31:32r]
req_ack  out  NREQ  one-cycle pulse: request accepted and channel bound
done  out  NREQ  one-cycle pulse: bound delay expired
busy  out  3  channel n bound to a requester
cyc_o  out  1  Wishbone cycle to PIT
stb_o  out  1  Wishbone strobe
we_o  out  1  always 1 during a cycle (writes only)
sel_o  out  4  byte selects
adr_o  out  6  PIT register address
dat_o  out  32  write data
ack_i  in  1  PIT ack
pit_out  in  3  PIT out0..out2

Behaviour:
- Reset (async, active-high): state IDLE. cyc_o, stb_o, we_o, req_ack, done, busy = 0. sel_o, adr_o, dat_o = 0. Round-robin pointer = 0. All owner tags = 0. pit_out history = 0. Reset mid-transaction drops cyc_o immediately. PIT channels left running are ignored, because busy=0 masks their edges.
- Arbitration (state IDLE only): grant requires at least one req bit set and at least one busy bit clear.
  - Requester: first set req at or after the pointer, wrapping modulo NREQ.
  - Channel: lowest-numbered clear busy bit.
  - On grant, in the same edge: latch requester r, channel n and D = delay[r]. A D of 0 is clamped to 1. Set busy[n] and owner[n]=r. Pulse req_ack[r]. Pointer becomes r+1 mod NREQ. Go to WR_MAX.
- Write states. Each state holds cyc_o=stb_o=we_o=1 until ack_i=1, then advances on that edge. The PIT acks writes in the same cycle, so each state lasts a minimum of 1 cycle.
  - WR_MAX: adr_o=16n+4, sel_o=4'hF, dat_o=D.
  - WR_ONT: adr_o=16n+8, sel_o=4'hF, dat_o=1.
  - WR_CTL: adr_o=6'h0C, sel_o=(1<<n), dat_o=32'h03<<(8n). This sets load and enable; auto-reload, external clock and gate-enable are 0.
  - After WR_CTL ack: go to IDLE. cyc_o/stb_o/we_o drop in the cycle after the ack.
- Request-to-programmed latency: 1 cycle (grant) + 3 write cycles. Only one write sequence is in flight at a time.
- Expiry:
  - pit_out is registered each clock. A falling edge on channel n with busy[n]=1 pulses done[owner[n]] and clears busy[n] on the same edge.
  - Edges on channels with busy=0 are ignored.
  - PIT behaviour gives a falling edge D+1 cycles after the load cycle, with out high during the cycle count==1.
- Simultaneous events:
  - Expiry and grant in the same cycle: the freed channel is not visible to the arbiter until the next cycle.
  - Two channels expiring together: both done pulses are issued (distinct or same owner, OR'd).
  - A requester may hold several channels; done pulses are ORed per requester.
- req deasserted before req_ack: request is withdrawn, nothing is programmed.
- No cancel path. A delay of 0xFFFFFFFF is legal and needs no special wrap handling, since the PIT counts down.

Test Plan:
- Reset then req[0]=1, delay[0]=10 -> req_ack[0] pulses 1 cycle after req. Writes occur in order: adr 0x04 data 10; adr 0x08 data 1; adr 0x0C sel 0001 data 0x03. busy=001. done[0] pulses 11 cycles after the WR_CTL ack cycle; busy returns to 000.
- req[0..3] all set with delays 50,60,70,80 -> grants in order r0→ch0, r1→ch1, r2→ch2. r3 waits until ch0 expires, then binds to ch0. The CTL write for ch1 uses sel 0010 and data 0x0300.
- Pointer fairness: after r3 is granted, req[0] and req[3] both asserted with a channel free -> r0 is granted first.
- delay=0 -> programmed maxcount is 1, and done arrives 2 cycles after the CTL ack.
- Bench stalls ack_i for 3 cycles in WR_ONT -> cyc_o/stb_o/adr_o=0x08 held stable throughout, and the sequence completes correctly.
- Assert rst_i mid-WR_MAX -> cyc_o falls without a clock edge, busy=000. A later pit_out falling edge produces no done.
